spi_flash_reader: RTL and testbench

Single-word read controller for the external SPI NOR flash on the DSOC top-level pins (flash_cs_n, flash_mosi_o, flash_miso_i, plus a generated serial clock). It accepts a 24-bit byte address from an internal requester, such as the boot loader or the memory-mapped flash window. It issues a standard READ (0x03) transaction in SPI mode 0 and returns one 32-bit little-endian word. One transaction is in flight at a time; the block owns the flash pins exclusively.

---
 rtl/spi_flash_reader.sv | 174 +++++++++++++++++
 tb/tb_spi_flash_reader.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_reader.sv
// Single-word SPI NOR flash reader. Each accepted request runs one READ (0x03)
// transaction in SPI mode 0 and returns four bytes as a little-endian word.
// SCK is derived from clk_i with a half-period of CLK_DIV cycles.
module spi_flash_reader #(
  parameter int CLK_DIV = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_i,
  input  logic [23:0] addr_i,
  output logic        ready_o,
  output logic        valid_o,
  output logic [31:0] data_o,
  output logic        flash_cs_n,
  output logic        flash_sclk_o,
  output logic        flash_mosi_o,
  input  logic        flash_miso_i
);

  localparam int               DIV_W    = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [7:0]       CMD_READ = 8'h03;
  localparam logic [6:0]       RX_FIRST = 7'd32;  // first SCK period that carries read data
  localparam logic [6:0]       LAST_BIT = 7'd63;  // final SCK period of the transfer

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_HOLD,
    S_DESEL
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [6:0]       bit_q, bit_d;     // completed SCK periods; reused as half-counter in DESEL
  logic [31:0]      tx_q, tx_d;
  logic [31:0]      rx_q, rx_d;
  logic [31:0]      data_q, data_d;
  logic             cs_n_q, cs_n_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic             div_wrap;

  // One SCK half-period (or hold/deselect slice) has elapsed.
  assign div_wrap = (div_q == DIV_LAST);

  // Next-state and output computation for the transaction sequencer.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves a
    // value unassigned and no latch can be inferred.
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    data_d  = data_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    ready_d = ready_q;
    valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_i && ready_q) begin
          tx_d    = {CMD_READ, addr_i};
          mosi_d  = tx_d[31];
          rx_d    = '0;
          div_d   = '0;
          bit_d   = '0;
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
          ready_d = 1'b0;
          state_d = S_XFER;
        end
      end

      S_XFER: begin
        div_d = div_q + DIV_ONE;
        if (div_wrap) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            // Rising SCK: the flash has held MISO stable since the last fall.
            if (bit_q >= RX_FIRST) begin
              rx_d = {rx_q[30:0], flash_miso_i};
            end
          end else begin
            // Falling SCK: advance to the next TX bit; zeros fill in behind.
            bit_d  = bit_q + 7'd1;
            tx_d   = {tx_q[30:0], 1'b0};
            mosi_d = tx_q[30];
            if (bit_q == LAST_BIT) begin
              state_d = S_HOLD;
            end
          end
        end
      end

      S_HOLD: begin
        div_d = div_q + DIV_ONE;
        if (div_wrap) begin
          div_d   = '0;
          bit_d   = '0;
          cs_n_d  = 1'b1;
          valid_d = 1'b1;
          // First received byte sits at rx_q[31:24] and belongs in the low lane.
          data_d  = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
          state_d = S_DESEL;
        end
      end

      S_DESEL: begin
        // Two divider rounds give a CS high time of 2*CLK_DIV cycles.
        div_d = div_q + DIV_ONE;
        if (div_wrap) begin
          div_d = '0;
          if (bit_q[0]) begin
            ready_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            bit_d = 7'd1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments here so every flop samples the pre-edge
    // values regardless of statement order.
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      data_q  <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      data_q  <= data_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign ready_o      = ready_q;
  assign valid_o      = valid_q;
  assign data_o       = data_q;
  assign flash_cs_n   = cs_n_q;
  assign flash_sclk_o = sclk_q;
  assign flash_mosi_o = mosi_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Self-checking bench for spi_flash_reader. Two instances (CLK_DIV=1 and 3)
// run the same scenario, each against its own behavioural SPI flash model.
// Expected words are pushed at acceptance and popped by a monitor on valid_o.
// All latencies are counted in clk edges after the acceptance edge.
module tb_spi_flash_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int D = (g == 0) ? 1 : 3;

    logic        rst_n = 1'b0;
    logic        req   = 1'b0;
    logic [23:0] addr  = '0;
    logic        ready, valid;
    logic [31:0] data;
    logic        cs_n, sclk, mosi;
    logic        miso  = 1'b0;
    bit          done  = 1'b0;

    spi_flash_reader #(.CLK_DIV(D)) u_dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .req_i       (req),
      .addr_i      (addr),
      .ready_o     (ready),
      .valid_o     (valid),
      .data_o      (data),
      .flash_cs_n  (cs_n),
      .flash_sclk_o(sclk),
      .flash_mosi_o(mosi),
      .flash_miso_i(miso)
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      check($sformatf("D%0d_%s", D, n), a, e);
    endtask

    // ---------------- flash contents: explicit bytes over a keyed pattern
    logic [7:0] mem [logic [23:0]];
    logic [7:0] pat_key;

    function automatic logic [7:0] mem_rd(input logic [23:0] a);
      if (mem.exists(a)) return mem[a];
      return a[7:0] ^ a[15:8] ^ {a[20:16], a[23:21]} ^ pat_key;
    endfunction

    function automatic logic [31:0] exp_word(input logic [23:0] a);
      return {mem_rd(a + 24'd3), mem_rd(a + 24'd2), mem_rd(a + 24'd1), mem_rd(a)};
    endfunction

    // ---------------- scoreboard
    typedef struct {
      logic [31:0] word;
      logic [23:0] addr;
      int          acc;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_new, e_pop;
    int   cyc        = 0;
    bit   reset_edge = 1'b1;
    int   acc_last   = -1;
    int   acc_prev   = -1;

    always @(posedge clk) begin
      cyc++;
      reset_edge = !rst_n;
      if (!rst_n) begin
        exp_q.delete();
      end else if (req && ready) begin
        e_new.word = exp_word(addr);
        e_new.addr = addr;
        e_new.acc  = cyc;
        exp_q.push_back(e_new);
        acc_prev = acc_last;
        acc_last = cyc;
      end
    end

    // ---------------- flash slave model (mode 0)
    int          f_cnt = 0;
    logic [31:0] f_cmd = '0;
    int          mosi_bad = 0;

    always @(negedge cs_n) begin
      f_cnt = 0;
      f_cmd = '0;
    end

    always @(posedge cs_n) f_cnt = 0;

    always @(posedge sclk) begin
      if (cs_n === 1'b0) begin
        if (f_cnt < 32) f_cmd = {f_cmd[30:0], mosi};
        else if (mosi !== 1'b0) mosi_bad++;
        f_cnt++;
        if (f_cnt == 32) begin
          if (exp_q.size() != 0) chk("mosi_cmd", f_cmd, {8'h03, exp_q[0].addr});
          else chk("mosi_cmd_without_request", f_cmd, 32'hxxxxxxxx);
        end
      end
    end

    always @(negedge sclk) begin : flash_tx
      int         j;
      logic [7:0] b;
      if (cs_n === 1'b0 && f_cnt >= 32 && f_cnt < 64) begin
        j    = f_cnt - 32;
        b    = mem_rd(f_cmd[23:0] + 24'(j / 8));
        miso = b[7 - (j % 8)];
      end
    end

    // ---------------- output monitor
    int   ready_due  = -1;
    int   run        = 0;
    int   activity   = 0;
    int   mosi_hi_chg = 0;
    logic prev_ready = 1'b1;
    logic prev_valid = 1'b0;
    logic prev_cs    = 1'b1;
    logic prev_sclk  = 1'b0;
    logic prev_mosi  = 1'b0;

    always @(negedge clk) begin
      if (valid === 1'b1) begin
        chk("valid_one_cycle", {31'b0, prev_valid}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("valid_without_request", {31'b0, valid}, 32'd0);
        end else begin
          e_pop = exp_q.pop_front();
          chk("data", data, e_pop.word);
          chk("valid_latency", cyc - e_pop.acc, 129 * D);
          ready_due = e_pop.acc + 131 * D;
        end
      end
      if (ready === 1'b1 && prev_ready === 1'b0 && !reset_edge)
        chk("ready_latency", cyc, ready_due);

      // Every SCK phase inside a CS window lasts exactly D cycles.
      if (prev_cs !== 1'b0) begin
        run = 1;
      end else if (cs_n !== 1'b0 || sclk !== prev_sclk) begin
        if (!reset_edge) chk("sck_phase_len", run, D);
        run = 1;
      end else begin
        run++;
      end

      if (sclk === 1'b1 && mosi !== prev_mosi) mosi_hi_chg++;
      if (cs_n !== 1'b1 || sclk !== 1'b0) activity++;

      prev_ready = ready;
      prev_valid = valid;
      prev_cs    = cs_n;
      prev_sclk  = sclk;
      prev_mosi  = mosi;
    end

    // ---------------- stimulus
    task automatic do_read(input logic [23:0] a);
      int t = 0;
      @(negedge clk);
      req  = 1'b1;
      addr = a;
      do begin
        @(posedge clk);
        t++;
      end while (!ready && t < 2000);
      if (!ready) chk("accept_timeout", {31'b0, ready}, 32'd1);
      @(negedge clk);
      req  = 1'b0;
      addr = 24'($urandom);
    endtask

    task automatic wait_idle();
      int t = 0;
      while ((exp_q.size() != 0 || ready !== 1'b1) && t < 3000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 3000) chk("drain_timeout", exp_q.size(), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string n);
      chk({n, "_cs_n"},  {31'b0, cs_n},  32'd1);
      chk({n, "_sclk"},  {31'b0, sclk},  32'd0);
      chk({n, "_mosi"},  {31'b0, mosi},  32'd0);
      chk({n, "_ready"}, {31'b0, ready}, 32'd1);
      chk({n, "_valid"}, {31'b0, valid}, 32'd0);
      chk({n, "_data"},  data,           32'd0);
    endtask

    initial begin : driver
      int act0;
      int t;
      pat_key = 8'($urandom);

      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst_n = 1'b1;

      // Idle quiescence.
      act0 = activity;
      repeat (1000) @(negedge clk);
      chk("idle_activity", activity - act0, 32'd0);

      // Basic read.
      mem[24'h000000] = 8'h13;
      mem[24'h000001] = 8'h00;
      mem[24'h000002] = 8'h00;
      mem[24'h000003] = 8'h00;
      do_read(24'h000000);
      wait_idle();
      chk("basic_word", data, 32'h0000_0013);

      // Byte and bit order.
      mem[24'h12345C] = 8'hA1;
      mem[24'h12345D] = 8'hB2;
      mem[24'h12345E] = 8'hC3;
      mem[24'h12345F] = 8'hD4;
      do_read(24'h12345C);
      wait_idle();
      chk("order_word", data, 32'hD4C3_B2A1);

      // Busy: req held, address changed mid-transaction.
      @(negedge clk);
      req  = 1'b1;
      addr = 24'h000100;
      t = 0;
      do begin @(posedge clk); t++; end while (!ready && t < 2000);
      repeat (5) @(negedge clk);
      addr = 24'hFFFFFF;
      t = 0;
      do begin @(posedge clk); t++; end while (!ready && t < 2000);
      @(negedge clk);
      req = 1'b0;
      chk("b2b_accept_gap", acc_last - acc_prev, 131 * D + 1);
      wait_idle();
      chk("busy_second_word", data, exp_word(24'hFFFFFF));

      // Address wrap.
      mem[24'hFFFFFE] = 8'hFF;
      mem[24'hFFFFFF] = 8'hFE;
      mem[24'h000000] = 8'h11;
      mem[24'h000001] = 8'h22;
      do_read(24'hFFFFFE);
      wait_idle();
      chk("wrap_word", data, 32'h2211_FEFF);

      // Reset 40 cycles into a read.
      do_read(24'($urandom));
      repeat (39) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk_reset_outputs("midreset");
      rst_n = 1'b1;
      repeat (300) @(negedge clk);
      chk("midreset_data_held", data, 32'd0);
      do_read(24'h000400);
      wait_idle();
      chk("post_reset_word", data, exp_word(24'h000400));

      // Randomized reads, sometimes back-to-back.
      for (int i = 0; i < 6; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        do_read(24'($urandom));
        if ($urandom_range(0, 1) == 1) wait_idle();
      end
      wait_idle();

      chk("mosi_zero_after_tx", mosi_bad, 32'd0);
      chk("mosi_stable_sck_high", mosi_hi_chg, 32'd0);
      done = 1'b1;
    end
  end

  initial begin : finisher
    int t = 0;
    while (!(g_inst[0].done && g_inst[1].done) && t < 60000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 60000) check("global_timeout", t, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
